// File: rtl/ysyx_23060096_alu_pipe.sv
// ysyx_23060096_alu_pipe
//   Registered execute-stage ALU with valid/ready handshakes on both sides.
//   One operation in flight. Single-cycle ops deliver their result one cycle
//   after accept; the result stays stable while the consumer stalls.
//
//   Optional multiplier: define YSYX_23060096_ALU_MUL_EN to build the radix-2
//   shift-add multiplier (MUL / MULHU, WIDTH busy cycles). Without it ops 12/13
//   complete in one cycle as reserved ops (err=1, result=0).
//
// Ports
//   clk, rst_n           clock, async active-low reset
//   in_valid / in_ready  request handshake (op, a, b sampled on accept)
//   out_valid/out_ready  response handshake
//   result, zero, carry, overflow, err   registered response
//
// Op codes: 0 ADD 1 SUB 2 NOT 3 AND 4 OR 5 XOR 6 SLT 7 EQ 8 SLTU 9 SLL
//           10 SRL 11 SRA 12 MUL 13 MULHU 14-15 reserved
module ysyx_23060096_alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_EQ   = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_SLL  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             z;
    logic             c;
    logic             v;
    logic             e;
  } rsp_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DONE
`ifdef YSYX_23060096_ALU_MUL_EN
    ,S_BUSY
`endif
  } state_t;

  state_t           state_q, state_d;
  rsp_t             alu_rsp, rsp_q;
  logic             live_q;   // low until the first edge after reset
  logic             accept;
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   add_s, sub_s;
  logic [WIDTH-1:0] sra_v;

  assign sh     = b[SHW-1:0];
  assign add_s  = {1'b0, a} + {1'b0, b};
  assign sub_s  = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
  assign sra_v  = $signed(a) >>> sh;
  assign accept = in_valid && in_ready;

  // ---------------------------------------------------------------- ALU
  always_comb begin
    alu_rsp = '0;
    case (op)
      OP_ADD: begin
        alu_rsp.res = add_s[MSB:0];
        alu_rsp.c   = add_s[WIDTH];
        alu_rsp.v   = (a[MSB] == b[MSB]) && (add_s[MSB] != a[MSB]);
      end
      OP_SUB: begin
        alu_rsp.res = sub_s[MSB:0];
        alu_rsp.c   = sub_s[WIDTH];
        alu_rsp.v   = (a[MSB] != b[MSB]) && (sub_s[MSB] != a[MSB]);
      end
      OP_NOT:  alu_rsp.res = ~a;
      OP_AND:  alu_rsp.res = a & b;
      OP_OR:   alu_rsp.res = a | b;
      OP_XOR:  alu_rsp.res = a ^ b;
      OP_SLT:  alu_rsp.res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_EQ:   alu_rsp.res = {{(WIDTH-1){1'b0}}, a == b};
      OP_SLTU: alu_rsp.res = {{(WIDTH-1){1'b0}}, a < b};
      OP_SLL:  alu_rsp.res = a << sh;
      OP_SRL:  alu_rsp.res = a >> sh;
      OP_SRA:  alu_rsp.res = sra_v;
      // reserved (and 12/13 when the multiplier is not built)
      default: alu_rsp.e = 1'b1;
    endcase
    // zero tracks the result even for reserved ops (result 0 -> zero 1)
    alu_rsp.z = (alu_rsp.res == '0);
  end

`ifdef YSYX_23060096_ALU_MUL_EN
  // --------------------------------------------------------- multiplier
  // Right-shifting product: low half starts as the multiplier, each step
  // conditionally adds the multiplicand into the high half then shifts.
  logic [2*WIDTH-1:0] prod_q, prod_nx;
  logic [WIDTH-1:0]   mcand_q, mul_res;
  logic [WIDTH:0]     psum;
  logic [SHW-1:0]     cnt_q;
  logic               hi_q, is_mul, cnt_last;
  rsp_t               mul_rsp;

  assign is_mul   = (op == 4'd12) || (op == 4'd13);
  assign psum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_nx  = {psum, prod_q[WIDTH-1:1]};
  assign cnt_last = (cnt_q == SHW'(WIDTH-1));
  assign mul_res  = hi_q ? prod_nx[2*WIDTH-1:WIDTH] : prod_nx[WIDTH-1:0];

  always_comb begin
    mul_rsp     = '0;
    mul_rsp.res = mul_res;
    mul_rsp.z   = (mul_res == '0);
  end
`endif

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      S_IDLE: in_ready = live_q;
      S_DONE: in_ready = out_ready;
`ifdef YSYX_23060096_ALU_MUL_EN
      S_BUSY: if (cnt_last) state_d = S_DONE;
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef YSYX_23060096_ALU_MUL_EN
    if (accept) state_d = is_mul ? S_BUSY : S_DONE;
`else
    if (accept) state_d = S_DONE;
`endif
    else if (state_q == S_DONE && out_ready) state_d = S_IDLE;
  end

  // ------------------------------------------------------------ datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q   <= '0;
      live_q  <= 1'b0;
`ifdef YSYX_23060096_ALU_MUL_EN
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      hi_q    <= 1'b0;
`endif
    end else begin
      live_q <= 1'b1;
`ifdef YSYX_23060096_ALU_MUL_EN
      if (accept && is_mul) begin
        mcand_q <= a;
        prod_q  <= {{WIDTH{1'b0}}, b};
        hi_q    <= op[0];
        cnt_q   <= '0;
      end else if (accept) begin
        rsp_q <= alu_rsp;
      end else if (state_q == S_BUSY) begin
        prod_q <= prod_nx;
        cnt_q  <= cnt_q + SHW'(1);
        if (cnt_last) rsp_q <= mul_rsp;
      end
`else
      if (accept) rsp_q <= alu_rsp;
`endif
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign result    = rsp_q.res;
  assign zero      = rsp_q.z;
  assign carry     = rsp_q.c;
  assign overflow  = rsp_q.v;
  assign err       = rsp_q.e;

endmodule

// File: tb/tb_ysyx_23060096_alu_pipe.sv
// Scoreboard bench for ysyx_23060096_alu_pipe (WIDTH=32).
// The driver pushes the reference-model response on every accept; an
// independent monitor checks latency, hold stability and data on output.
module tb_ysyx_23060096_alu_pipe;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  op;
  logic [31:0] a, b, result;
  logic        zero, carry, overflow, err;

  ysyx_23060096_alu_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry), .overflow(overflow), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] res;
    logic        z, c, v, e;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        q[$];
  int          total = 0, bad = 0, cyc = 0;
  bit          head_seen = 0, held = 0, rnd_bp = 0;
  logic [35:0] hold_v;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: plain arithmetic on wide integers.
  function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        r;
    longint      sx, sy, s;
    logic [63:0] p;
    int          sh;
    r = '{op: o, res: 32'h0, z: 1'b0, c: 1'b0, v: 1'b0, e: 1'b0, acc: 0, lat: 1};
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = int'(y[4:0]);
    case (o)
      4'd0: begin
        p = {32'h0, x} + {32'h0, y};
        r.res = p[31:0]; r.c = p[32];
        s = sx + sy; r.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd1: begin
        r.res = x - y; r.c = (x >= y);
        s = sx - sy; r.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2:  r.res = ~x;
      4'd3:  r.res = x & y;
      4'd4:  r.res = x | y;
      4'd5:  r.res = x ^ y;
      4'd6:  r.res = (sx < sy) ? 32'd1 : 32'd0;
      4'd7:  r.res = (x == y) ? 32'd1 : 32'd0;
      4'd8:  r.res = (x < y) ? 32'd1 : 32'd0;
      4'd9:  r.res = x << sh;
      4'd10: r.res = x >> sh;
      4'd11: begin s = sx >>> sh; r.res = s[31:0]; end
`ifdef YSYX_23060096_ALU_MUL_EN
      4'd12, 4'd13: begin
        p = {32'h0, x} * {32'h0, y};
        r.res = (o == 4'd13) ? p[63:32] : p[31:0];
        r.lat = 33;
      end
`endif
      default: r.e = 1'b1;
    endcase
    r.z = (r.res == 32'h0);
    return r;
  endfunction

  // Drive one request (called at posedge+1); returns cycles stalled.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, output int stalls);
    exp_t e;
    stalls = 0;
    in_valid = 1'b1; op = o; a = x; b = y;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        e = model(o, x, y);
        e.acc = cyc;
        q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        break;
      end
      @(posedge clk); #1;
      stalls++;
      if (stalls > 300) begin
        chk("issue_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    head_seen = 0;
    held = 0;
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", {in_ready, out_valid, result, zero, carry, overflow, err}, 64'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_before_first_edge", in_ready, 1'b0);
    @(negedge clk);
    chk("ready_after_first_edge", {in_ready, out_valid}, 2'b10);
    @(posedge clk); #1;
  endtask

  // Monitor: sampled on the falling edge, handshake completes at the next rise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", out_valid, 1'b0);
        end else begin
          if (!head_seen) begin
            chk($sformatf("latency op%0d", q[0].op), cyc, q[0].acc + q[0].lat);
            head_seen = 1;
          end else if (held) begin
            chk("hold_stable", {result, zero, carry, overflow, err}, hold_v);
          end
          chk("in_ready_in_done", in_ready, out_ready);
          if (out_ready) begin
            chk($sformatf("resp op%0d", q[0].op), {result, zero, carry, overflow, err},
                {q[0].res, q[0].z, q[0].c, q[0].v, q[0].e});
            void'(q.pop_front());
            head_seen = 0;
            held = 0;
          end else begin
            held = 1;
            hold_v = {result, zero, carry, overflow, err};
          end
        end
      end else if (held) begin
        chk("hold_valid_dropped", out_valid, 1'b1);
        held = 0;
      end
    end
  end

  // Random backpressure while enabled.
  initial forever begin
    @(posedge clk); #1;
    if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, w;
    logic [31:0] x, y;
    logic [31:0] specials [4];
    specials[0] = 32'h0; specials[1] = 32'hFFFF_FFFF;
    specials[2] = 32'h8000_0000; specials[3] = 32'h7FFF_FFFF;
    in_valid = 1'b0; op = 4'd0; a = '0; b = '0; out_ready = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // ADD carry / overflow corners
    issue(4'd0, 32'hFFFF_FFFF, 32'd1, st);
    issue(4'd0, 32'h7FFF_FFFF, 32'd1, st);
    @(posedge clk); #1;

    // back-to-back throughput
    issue(4'd1, 32'd5, 32'd7, st);               chk("b2b_stall_sub", st, 0);
    issue(4'd6, 32'hFFFF_FFFF, 32'd0, st);       chk("b2b_stall_slt", st, 0);
    issue(4'd8, 32'hFFFF_FFFF, 32'd0, st);       chk("b2b_stall_sltu", st, 0);
    issue(4'd11, 32'h8000_0000, 32'd4, st);      chk("b2b_stall_sra", st, 0);
    @(posedge clk); #1;
    out_ready = 1'b0;

    // backpressure: XOR held five cycles, queued ADD accepted on release
    issue(4'd5, 32'h0000_F0F0, 32'h0000_0FF0, st);
    fork
      begin
        int s2;
        issue(4'd0, 32'd3, 32'd4, s2);
        chk("bp_stall_cycles", s2, 5);
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    @(posedge clk); #1;

    // reset while a result is held
    out_ready = 1'b0;
    issue(4'd3, 32'hDEAD_BEEF, 32'h0F0F_0F0F, st);
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    out_ready = 1'b1;

    // reserved ops and 12/13
    issue(4'd14, 32'h1234, 32'h5678, st);
    issue(4'd15, 32'hFFFF_FFFF, 32'h1, st);
    issue(4'd12, 32'h1234_5678, 32'h10, st);
    issue(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st);
    repeat (40) @(posedge clk);
    #1;

`ifdef YSYX_23060096_ALU_MUL_EN
    // abort mid-multiply
    issue(4'd12, 32'h0000_0003, 32'h0000_0005, st);
    repeat (9) @(posedge clk);
    #1;
    do_reset();
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("no_valid_after_abort", out_valid, 1'b0);
    @(posedge clk); #1;
    issue(4'd0, 32'd10, 32'd20, st);
    repeat (3) @(posedge clk);
    #1;
`endif

    // randomized traffic with random backpressure
    rnd_bp = 1;
    for (int i = 0; i < 300; i++) begin
      x = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      y = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40));
      if ($urandom_range(0, 4) == 0) y = specials[$urandom_range(0, 3)];
      issue(4'($urandom_range(0, 15)), x, y, st);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    rnd_bp = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    w = 0;
    while (q.size() != 0 && w < 100) begin @(posedge clk); w++; end
    chk("drain_queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ysyx_23060096_alu_pipe.md
Name: ysyx_23060096_alu_pipe

Overview:
Parametrised, registered successor to the combinational execute-stage ALU. Adds valid/ready handshakes on input and output, sticky result holding under backpressure, shifts, and unsigned compare. Behind a macro, it adds an iterative multi-cycle multiplier. Sits between decode and writeback in the NPC core; one operation in flight at a time.

Parameters:
WIDTH, 32, operand/result width; power of 2, >= 4
SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request
in_ready  output  1  block can accept a request this cycle
op  input  4  operation code (encoding below)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result/flags valid
out_ready  input  1  consumer takes result this cycle
result  output  WIDTH  registered result
zero  output  1  result == 0
carry  output  1  carry-out (ADD: a+b; SUB: a+~b+1), else 0
overflow  output  1  signed overflow (ADD/SUB only), else 0
err  output  1  unsupported/reserved op was executed

Behaviour:
- Clock/reset: one clock clk; reset rst_n is asynchronous, active-low. While rst_n=0, all outputs are 0 except in_ready (also 0); state=IDLE. After deassertion, in_ready=1 from the first clock edge.
- Op codes: 0 ADD, 1 SUB, 2 NOT a, 3 AND, 4 OR, 5 XOR, 6 SLT (signed a<b -> 1), 7 EQ (a==b -> 1), 8 SLTU, 9 SLL, 10 SRL, 11 SRA, 12 MUL (low WIDTH bits), 13 MULHU (high WIDTH bits, unsigned), 14-15 reserved.
- Shifts use b[SHW-1:0]; upper b bits are ignored. SRA replicates a[WIDTH-1].
- Compare results are zero-extended to WIDTH.
- Reserved op: result=0, err=1, flags=0; completes with single-cycle latency.
- FSM states:
  - IDLE: in_ready=1.
  - BUSY: multiplier iterating; in_ready=0.
  - DONE: out_valid=1; in_ready=out_ready.
- Accept occurs when in_valid && in_ready at a rising edge. Single-cycle op -> DONE; MUL/MULHU -> BUSY.
- Single-cycle latency: result is registered at the accept edge; out_valid=1 in the following cycle.
- Multiplier: radix-2 shift-add over a 2*WIDTH product register. BUSY lasts exactly WIDTH cycles, then DONE. out_valid rises WIDTH+1 cycles after the accept cycle.
- DONE && out_ready && !in_valid -> IDLE; out_valid drops next cycle.
- DONE && out_ready && in_valid: back-to-back accept.
  - Single-cycle op: stays DONE with the new result (throughput 1 op/cycle).
  - MUL: goes to BUSY.
- DONE && !out_ready: result, flags, err and out_valid are held stable; in_valid is ignored; op/a/b may change freely.
- Operands are captured at accept; input changes during BUSY have no effect.
- zero always reflects the final registered result. carry/overflow are defined only for ADD/SUB.
- Reset asserted mid-BUSY or in DONE: operation aborted, outputs cleared asynchronously, no result delivered.

Optional Feature:
YSYX_23060096_ALU_MUL_EN
- Defined: multiplier datapath and BUSY state present; op 12/13 behave as above.
- Undefined: no multiplier logic or BUSY state. Op 12/13 are treated as reserved: result=0, err=1, single-cycle latency.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles mid-stream -> all outputs 0. Release -> in_ready=1 on the first edge, out_valid=0.
- ADD with WIDTH=32, a=32'hFFFF_FFFF, b=1 -> result=0, zero=1, carry=1, overflow=0. Then a=32'h7FFF_FFFF, b=1 -> result=32'h8000_0000, overflow=1, carry=0. Each result appears 1 cycle after accept.
- Back-to-back throughput: out_ready=1 held; SUB(5,7), SLT(-1,0), SLTU(-1,0), SRA(32'h8000_0000, 4) on consecutive cycles -> results 32'hFFFF_FFFE, 1, 0, 32'hF800_0000 on consecutive cycles, in_ready=1 throughout.
- Backpressure: out_ready=0 for 5 cycles after XOR(32'hF0F0, 32'h0FF0) -> result=32'hFF00 held, in_ready=0, new in_valid not accepted. Raise out_ready -> next request accepted that cycle.
- MUL (macro on): MUL(32'h1234_5678, 32'h10) -> result=32'h2345_6780 after 33 cycles. MULHU(32'hFFFF_FFFF, 32'hFFFF_FFFF) -> 32'hFFFF_FFFE. Assert rst_n=0 at BUSY cycle 10 -> no out_valid; the next ADD completes normally.
- Reserved/macro off: op=14 -> err=1, result=0. With macro undefined, op=12 -> err=1, result=0, single-cycle latency.
